// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and helpers for the serial-in/parallel-out receiver.
// Holds default configuration, the hold-register event encoding and count sizing.
package sipo_pkg;

    // Default configuration matches the team PISO (8-bit, MSB first).
    localparam int SIPO_DEF_WIDTH     = 8;
    localparam bit SIPO_DEF_MSB_FIRST = 1'b1;

    // What the holding register does on a given edge.
    typedef enum logic [1:0] {
        HOLD_IDLE = 2'd0,
        HOLD_LOAD = 2'd1,
        HOLD_DROP = 2'd2,
        HOLD_ACK  = 2'd3
    } hold_ev_e;

    // Bit counter must reach WIDTH-1 and still have headroom.
    function automatic int cnt_bits(input int width);
        return $clog2(width) + 1;
    endfunction

    // Completion outranks acknowledge: a word landing while the consumer
    // acks replaces the old one; landing while unacked is dropped.
    function automatic hold_ev_e hold_event(
        input logic done,
        input logic valid,
        input logic ack
    );
        hold_ev_e ev;
        ev = HOLD_IDLE;
        if (done) begin
            if (!valid || ack) begin
                ev = HOLD_LOAD;
            end else begin
                ev = HOLD_DROP;
            end
        end else if (valid && ack) begin
            ev = HOLD_ACK;
        end
        return ev;
    endfunction

endpackage

// File: rtl/sipo_hold.sv
// sipo_hold: output holding register with valid/ack handshake.
// Also owns the sticky overrun flag for words dropped while unacked.
module sipo_hold
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_done,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_dack,
    input  logic             i_ovr_clr,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dvalid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_dout;
    logic             r_dvalid;
    logic             r_overrun;
    hold_ev_e         w_ev;

    // Classify this edge from completion, current valid and ack.
    always_comb begin
        w_ev = hold_event(i_done, r_dvalid, i_dack);
    end

    // Load a new word or retire the current one on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout   <= '0;
            r_dvalid <= 1'b0;
        end else begin
            unique case (w_ev)
                HOLD_LOAD: begin
                    r_dout   <= i_word;
                    r_dvalid <= 1'b1;
                end
                HOLD_ACK: begin
                    r_dvalid <= 1'b0;
                end
                HOLD_DROP: begin
                    r_dvalid <= r_dvalid;
                end
                default: begin
                    r_dvalid <= r_dvalid;
                end
            endcase
        end
    end

    // Sticky overrun; a drop on the clearing edge keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_ev == HOLD_DROP) begin
            r_overrun <= 1'b1;
        end else if (i_ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_dout    = r_dout;
    assign o_dvalid  = r_dvalid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo.sv
// sipo: serial-in/parallel-out receiver, receive end of the PISO link.
// Shifts one bit per enabled edge; completed words go to sipo_hold.
module sipo
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEF_WIDTH,
    parameter bit MSB_FIRST = SIPO_DEF_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser,
    input  logic             en,
    input  logic             sync,
    input  logic             dack,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = cnt_bits(WIDTH);

    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_sh_next;
    logic             w_done;

    // The shifted value is also the assembled word on the completing edge,
    // since old bits have fully shifted out by then.
    if (MSB_FIRST) begin : g_msb
        assign w_sh_next = {r_sh[WIDTH-2:0], ser};
    end else begin : g_lsb
        assign w_sh_next = {ser, r_sh[WIDTH-1:1]};
    end

    // A sync bit always starts a word, so it can never complete one.
    always_comb begin
        w_done = en && !sync && (r_cnt == CW'(WIDTH - 1));
    end

    // Shift register advances only on enabled bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh <= '0;
        end else if (en) begin
            r_sh <= w_sh_next;
        end
    end

    // Bit position within the current word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            if (sync) begin
                r_cnt <= CW'(1);
            end else if (w_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign busy = (r_cnt != '0);

    sipo_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .i_done    (w_done),
        .i_word    (w_sh_next),
        .i_dack    (dack),
        .i_ovr_clr (ovr_clr),
        .o_dout    (dout),
        .o_dvalid  (dvalid),
        .o_overrun (overrun)
    );

endmodule

// File: tb/tb_sipo.sv
// tb_sipo: scoreboard bench for sipo, MSB-first and LSB-first instances
// fed the same serial stream and checked against a bit-list reference model.
module tb_sipo;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         ser;
    logic         en;
    logic         sync;
    logic         dack;
    logic         ovr_clr;
    logic [W-1:0] dout_m;
    logic [W-1:0] dout_l;
    logic         dv_m;
    logic         dv_l;
    logic         bz_m;
    logic         bz_l;
    logic         ov_m;
    logic         ov_l;

    always #5 clk = ~clk;

    sipo #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .ser(ser), .en(en), .sync(sync),
        .dack(dack), .ovr_clr(ovr_clr), .dout(dout_m),
        .dvalid(dv_m), .busy(bz_m), .overrun(ov_m)
    );

    sipo #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .ser(ser), .en(en), .sync(sync),
        .dack(dack), .ovr_clr(ovr_clr), .dout(dout_l),
        .dvalid(dv_l), .busy(bz_l), .overrun(ov_l)
    );

    typedef struct packed {
        logic         bz;
        logic         dv;
        logic         ov;
        logic [W-1:0] dm;
        logic [W-1:0] dl;
    } st_t;

    typedef struct packed {
        logic [W-1:0] m;
        logic [W-1:0] l;
    } wd_t;

    st_t          st_q[$];
    wd_t          wd_q[$];
    bit           bits[$];
    logic         m_v;
    logic         m_ov;
    logic [W-1:0] m_dm;
    logic [W-1:0] m_dl;
    int           n_err = 0;
    int           n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        bits.delete();
        m_v  = 1'b0;
        m_ov = 1'b0;
        m_dm = '0;
        m_dl = '0;
    endtask

    // Reference: a word is the list of bits since the last sync/boundary.
    task automatic model(input bit s, input bit e, input bit y, input bit a, input bit c);
        bit           done;
        bit           drop;
        logic [W-1:0] wm;
        logic [W-1:0] wl;
        done = 1'b0;
        drop = 1'b0;
        wm   = '0;
        wl   = '0;
        if (e) begin
            if (y) bits.delete();
            bits.push_back(s);
            if (bits.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    wm[W-1-i] = bits[i];
                    wl[i]     = bits[i];
                end
                bits.delete();
                done = 1'b1;
            end
        end
        if (done && (!m_v || a)) begin
            m_dm = wm;
            m_dl = wl;
            m_v  = 1'b1;
            wd_q.push_back('{m: wm, l: wl});
        end else if (done) begin
            drop = 1'b1;
        end else if (a) begin
            m_v = 1'b0;
        end
        if (drop) m_ov = 1'b1;
        else if (c) m_ov = 1'b0;
        st_q.push_back('{bz: (bits.size() != 0), dv: m_v, ov: m_ov, dm: m_dm, dl: m_dl});
    endtask

    // Drive one edge's inputs, record the expectation, advance past the edge.
    task automatic step(input bit s, input bit e, input bit y, input bit a, input bit c);
        ser     = s;
        en      = e;
        sync    = y;
        dack    = a;
        ovr_clr = c;
        model(s, e, y, a, c);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
        end
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit msb_order,
                             input int gap, input bit ack_first, input bit ack_last);
        bit b;
        for (int i = 0; i < W; i++) begin
            b = msb_order ? w[W-1-i] : w[i];
            step(b, 1'b1, i == 0, (i == 0 && ack_first) || (i == W-1 && ack_last), 1'b0);
            if (i < W-1) idle(gap);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout_m"}, dout_m, 0);
        chk({tag, "_dout_l"}, dout_l, 0);
        chk({tag, "_dv_m"}, dv_m, 0);
        chk({tag, "_dv_l"}, dv_l, 0);
        chk({tag, "_busy_m"}, bz_m, 0);
        chk({tag, "_busy_l"}, bz_l, 0);
        chk({tag, "_ovr_m"}, ov_m, 0);
        chk({tag, "_ovr_l"}, ov_l, 0);
    endtask

    // Asynchronous reset between edges; outputs must clear immediately.
    task automatic do_reset();
        #1;
        rst     = 1'b1;
        en      = 1'b0;
        sync    = 1'b0;
        dack    = 1'b0;
        ovr_clr = 1'b0;
        #1;
        chk_zero("async_rst");
        st_q.delete();
        wd_q.delete();
        model_clear();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: per-edge status check plus scoreboard pop on each new word.
    logic prev_v = 1'b0;
    st_t  mx;
    wd_t  wx;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (st_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL status_queue: got empty expected an entry at %0t", $time);
                end else begin
                    mx = st_q.pop_front();
                    chk("busy_m", bz_m, mx.bz);
                    chk("busy_l", bz_l, mx.bz);
                    chk("dvalid_m", dv_m, mx.dv);
                    chk("dvalid_l", dv_l, mx.dv);
                    chk("overrun_m", ov_m, mx.ov);
                    chk("overrun_l", ov_l, mx.ov);
                    chk("hold_m", dout_m, mx.dm);
                    chk("hold_l", dout_l, mx.dl);
                end
                if (dv_m && (!prev_v || dack)) begin
                    if (wd_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL word_queue: got word %0h expected none at %0t", dout_m, $time);
                    end else begin
                        wx = wd_q.pop_front();
                        chk("word_m", dout_m, wx.m);
                        chk("word_l", dout_l, wx.l);
                    end
                end
                prev_v = dv_m;
            end
        end
    end

    logic [W-1:0] piso_bytes [6];

    initial begin
        rst     = 1'b1;
        ser     = 1'b0;
        en      = 1'b0;
        sync    = 1'b0;
        dack    = 1'b0;
        ovr_clr = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Basic MSB-first 0x55, then ack.
        send_word(8'h55, 1'b1, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // LSB-first 0xCD with 3-cycle gaps.
        send_word(8'hCD, 1'b0, 3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Junk then resync onto 0xAA.
        for (int i = 0; i < 3; i++) step(1'($urandom_range(1)), 1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'hAA, 1'b1, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back: ack on completion, then overrun, then clear.
        send_word(8'h0F, 1'b1, 0, 1'b0, 1'b0);
        send_word(8'hF0, 1'b1, 0, 1'b0, 1'b1);
        send_word(8'hF0, 1'b1, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-word, then a clean 0x80.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0, 1'b0, 1'b0);
        do_reset();
        send_word(8'h80, 1'b1, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // PISO loopback: continuous MSB-first bytes, each acked as the next starts.
        piso_bytes = '{8'h55, 8'hAA, 8'h0F, 8'hCD, 8'h80, 8'hF0};
        for (int j = 0; j < 6; j++) send_word(piso_bytes[j], 1'b1, 0, j != 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(499) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(1)),
                     $urandom_range(9) < 7,
                     $urandom_range(19) == 0,
                     $urandom_range(3) == 0,
                     $urandom_range(9) == 0);
            end
        end
        idle(2);

        chk("status_left", st_q.size(), 0);
        chk("words_left", wd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
